// File: rtl/abus_pkg.sv
// abus_pkg: shared definitions for the abus interconnect.
//   ABUS_MAX_MASTERS : widest master vector any abus block supports
//   ABUS_IDX_W       : index width for ABUS_MAX_MASTERS
//   abus_idx_width() : index width for an N-master vector (at least 1 bit)
//   lsb_onehot()     : isolates the lowest set bit of a vector
//   onehot2bin()     : binary index of the set bit of a one-hot vector
package abus_pkg;

  localparam int ABUS_MAX_MASTERS = 32;
  localparam int ABUS_IDX_W       = $clog2(ABUS_MAX_MASTERS);

  typedef logic [ABUS_MAX_MASTERS-1:0] abus_vec_t;
  typedef logic [ABUS_IDX_W-1:0]       abus_idx_t;

  function automatic int abus_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Two's-complement trick: ~vec + 1 flips every bit above the lowest one.
  function automatic abus_vec_t lsb_onehot(input abus_vec_t vec);
    return vec & (~vec + abus_vec_t'(1));
  endfunction

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic abus_idx_t onehot2bin(input abus_vec_t vec);
    abus_idx_t idx;
    idx = '0;
    for (int i = 0; i < ABUS_MAX_MASTERS; i++) begin
      if (vec[i]) idx = idx | abus_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/abus_lf_arbiter_if.sv
// abus_lf_arbiter_if: request/grant bundle between abus masters and the
// lower-first arbiter.
//   req       : per-master request (master -> arbiter)
//   grant     : one-hot grant      (arbiter -> masters / bus mux)
//   grant_idx : binary grant index (arbiter -> bus mux select)
//   req_any   : any master requesting
// Modports: master (drives req), slave (the arbiter).
interface abus_lf_arbiter_if
  import abus_pkg::*;
#(
  parameter int N = 8
);
  localparam int IW = abus_idx_width(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          req_any;

  modport master (output req, input grant, input grant_idx, input req_any);
  modport slave  (input req, output grant, output grant_idx, output req_any);

endinterface

// File: rtl/abus_prio_lsb.sv
// abus_prio_lsb: N-bit lowest-one priority encoder (bit 0 wins).
//   req    : input request vector
//   onehot : lowest set bit of req (zero when req is zero)
//   index  : binary index of onehot
//   any    : OR-reduction of req
// N must not exceed ABUS_MAX_MASTERS.
module abus_prio_lsb
  import abus_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = abus_idx_width(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  abus_vec_t req_w;
  abus_vec_t onehot_w;
  abus_idx_t index_w;

  // Work at the package width so the shared helpers can be reused; the
  // zero padding above N cannot produce a set bit there.
  always_comb begin
    req_w          = '0;
    req_w[N-1:0]   = req;
    onehot_w       = lsb_onehot(req_w);
    index_w        = onehot2bin(onehot_w);
    onehot         = onehot_w[N-1:0];
    index          = index_w[IW-1:0];
    any            = |req;
  end

  if (N < ABUS_MAX_MASTERS) begin : g_pad_oh
    logic unused_oh_hi;
    assign unused_oh_hi = |onehot_w[ABUS_MAX_MASTERS-1:N];
  end

  if (IW < ABUS_IDX_W) begin : g_pad_idx
    logic unused_idx_hi;
    assign unused_idx_hi = |index_w[ABUS_IDX_W-1:IW];
  end

endmodule

// File: rtl/abus_lf_arbiter.sv
// abus_lf_arbiter: lower-first fixed-priority abus arbiter.
//   clk   : bus clock, park register updates on rising edge
//   rst_n : asynchronous active-low reset (park -> master 0)
//   bus   : abus_lf_arbiter_if.slave (req in; grant, grant_idx, req_any out)
// The lowest-indexed requester is granted combinationally. With no request
// the grant parks on the last winner, so grant is one-hot every cycle.
module abus_lf_arbiter
  import abus_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  abus_lf_arbiter_if.slave     bus
);

  localparam int            IW       = abus_idx_width(N);
  localparam logic [N-1:0]  PARK_RST = N'(1);

  logic [N-1:0]  enc_onehot;
  logic [IW-1:0] enc_idx;
  logic          enc_any;

  logic [N-1:0]  park_q;
  logic [N-1:0]  park_d;
  abus_vec_t     park_w;
  abus_idx_t     park_idx_w;
  logic [IW-1:0] park_idx;

  abus_prio_lsb #(.N(N)) u_prio (
    .req    (bus.req),
    .onehot (enc_onehot),
    .index  (enc_idx),
    .any    (enc_any)
  );

  // Index of the parked master, used when nobody requests.
  always_comb begin
    park_w         = '0;
    park_w[N-1:0]  = park_q;
    park_idx_w     = onehot2bin(park_w);
    park_idx       = park_idx_w[IW-1:0];
  end

  if (IW < ABUS_IDX_W) begin : g_pad_park
    logic unused_park_hi;
    assign unused_park_hi = |park_idx_w[ABUS_IDX_W-1:IW];
  end

  // Output mux: encoder result when requested, parked grant otherwise.
  always_comb begin
    bus.grant     = enc_any ? enc_onehot : park_q;
    bus.grant_idx = enc_any ? enc_idx    : park_idx;
    bus.req_any   = enc_any;
    park_d        = enc_any ? enc_onehot : park_q;
  end

  // Stage boundary: park register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) park_q <= PARK_RST;
    else        park_q <= park_d;
  end

endmodule

// File: tb/tb_abus_lf_arbiter.sv
// tb_abus_lf_arbiter: directed self-checking bench for abus_lf_arbiter
// (N = 8 instance plus an N = 1 instance).
module tb_abus_lf_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   mon_en;

  abus_lf_arbiter_if #(.N(8)) bus8 ();
  abus_lf_arbiter_if #(.N(1)) bus1 ();

  abus_lf_arbiter #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  abus_lf_arbiter #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_lsb(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 8'h01 << i;
    return r;
  endfunction

  // Every-cycle one-hot and index consistency check on the N=8 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [2:0] ei;
      ei = 3'd0;
      for (int i = 0; i < 8; i++) if (bus8.grant[i]) ei = 3'(i);
      checks++;
      if (!$onehot(bus8.grant)) begin
        errors++;
        $display("FAIL onehot grant=%h not one-hot", bus8.grant);
      end
      checks++;
      if (bus8.grant_idx !== ei) begin
        errors++;
        $display("FAIL idx_match grant_idx=%0d expected %0d (grant=%h)", bus8.grant_idx, ei, bus8.grant);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    bus8.req = 8'h00;
    bus1.req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.grant !== 8'h01) begin errors++; $display("FAIL rst_grant got %h want 01", bus8.grant); end
    checks++;
    if (bus8.grant_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got %0d want 0", bus8.grant_idx); end
    checks++;
    if (bus8.req_any !== 1'b0) begin errors++; $display("FAIL rst_req_any got %b want 0", bus8.req_any); end
    bus8.req = 8'h0C;
    #1;
    checks++;
    if (bus8.grant !== 8'h04) begin errors++; $display("FAIL rst_req_grant got %h want 04", bus8.grant); end
    bus8.req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_sweep();
    int         cnt [8];
    logic [7:0] park;
    logic [7:0] exp;
    int         mx;
    park = 8'h01;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int v = 0; v < 256; v++) begin
      @(posedge clk);
      #1 bus8.req = 8'(v);
      @(negedge clk);
      #1;
      exp = (v == 0) ? park : exp_lsb(8'(v));
      if (v != 0) park = exp;
      checks++;
      if (bus8.grant !== exp) begin
        errors++;
        $display("FAIL sweep req=%h grant=%h want %h", 8'(v), bus8.grant, exp);
      end
      checks++;
      if (bus8.req_any !== (v != 0)) begin
        errors++;
        $display("FAIL sweep_any req=%h req_any=%b", 8'(v), bus8.req_any);
      end
      for (int i = 0; i < 8; i++) if (bus8.grant[i]) cnt[i]++;
    end
    checks++; if (cnt[0] !== 129) begin errors++; $display("FAIL count0 got %0d want 129", cnt[0]); end
    checks++; if (cnt[1] !== 64)  begin errors++; $display("FAIL count1 got %0d want 64", cnt[1]); end
    checks++; if (cnt[2] !== 32)  begin errors++; $display("FAIL count2 got %0d want 32", cnt[2]); end
    checks++; if (cnt[3] !== 16)  begin errors++; $display("FAIL count3 got %0d want 16", cnt[3]); end
    checks++; if (cnt[4] !== 8)   begin errors++; $display("FAIL count4 got %0d want 8", cnt[4]); end
    checks++; if (cnt[5] !== 4)   begin errors++; $display("FAIL count5 got %0d want 4", cnt[5]); end
    checks++; if (cnt[6] !== 2)   begin errors++; $display("FAIL count6 got %0d want 2", cnt[6]); end
    checks++; if (cnt[7] !== 1)   begin errors++; $display("FAIL count7 got %0d want 1", cnt[7]); end
    mx = 0;
    for (int i = 1; i < 8; i++) if (cnt[i] > cnt[mx]) mx = i;
    checks++;
    if (mx !== 0) begin errors++; $display("FAIL count_max master %0d has max, want 0", mx); end
  endtask

  task automatic test_park();
    @(posedge clk);
    #1 bus8.req = 8'h08;
    @(posedge clk);
    #1 bus8.req = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus8.grant !== 8'h08) begin errors++; $display("FAIL park_grant cyc %0d got %h want 08", c, bus8.grant); end
      checks++;
      if (bus8.grant_idx !== 3'd3) begin errors++; $display("FAIL park_idx cyc %0d got %0d want 3", c, bus8.grant_idx); end
      @(posedge clk);
    end
    #1 bus8.req = 8'h30;
    @(negedge clk);
    #1;
    checks++;
    if (bus8.grant !== 8'h10) begin errors++; $display("FAIL park_next got %h want 10", bus8.grant); end
    checks++;
    if (bus8.grant_idx !== 3'd4) begin errors++; $display("FAIL park_next_idx got %0d want 4", bus8.grant_idx); end
  endtask

  task automatic test_priority();
    logic [7:0] rv [4];
    logic [7:0] gv [4];
    rv = '{8'hFF, 8'hFE, 8'h80, 8'hA0};
    gv = '{8'h01, 8'h02, 8'h80, 8'h20};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 bus8.req = rv[k];
      @(negedge clk);
      #1;
      checks++;
      if (bus8.grant !== gv[k]) begin
        errors++;
        $display("FAIL prio req=%h grant=%h want %h", rv[k], bus8.grant, gv[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1 bus8.req = 8'h40;
    @(posedge clk);
    #1 bus8.req = 8'h00;
    @(negedge clk);
    #1;
    checks++;
    if (bus8.grant !== 8'h40) begin errors++; $display("FAIL mid_park got %h want 40", bus8.grant); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.grant !== 8'h01) begin errors++; $display("FAIL mid_rst_grant got %h want 01", bus8.grant); end
    checks++;
    if (bus8.grant_idx !== 3'd0) begin errors++; $display("FAIL mid_rst_idx got %0d want 0", bus8.grant_idx); end
    checks++;
    if (bus8.req_any !== 1'b0) begin errors++; $display("FAIL mid_rst_any got %b want 0", bus8.req_any); end
    bus8.req = 8'h04;
    #1;
    checks++;
    if (bus8.grant !== 8'h04) begin errors++; $display("FAIL mid_rst_req got %h want 04", bus8.grant); end
    checks++;
    if (bus8.grant_idx !== 3'd2) begin errors++; $display("FAIL mid_rst_req_idx got %0d want 2", bus8.grant_idx); end
    @(posedge clk);
    #1 bus8.req = 8'h00;
    #1;
    checks++;
    if (bus8.grant !== 8'h01) begin errors++; $display("FAIL mid_rst_hold got %h want 01", bus8.grant); end
    @(negedge clk);
    #1 rst_n = 1'b1;
    bus8.req = 8'h20;
    @(posedge clk);
    #1 bus8.req = 8'h00;
    @(negedge clk);
    #1;
    checks++;
    if (bus8.grant !== 8'h20) begin errors++; $display("FAIL mid_release got %h want 20", bus8.grant); end
    checks++;
    if (bus8.grant_idx !== 3'd5) begin errors++; $display("FAIL mid_release_idx got %0d want 5", bus8.grant_idx); end
  endtask

  task automatic test_n1();
    for (int v = 0; v < 2; v++) begin
      @(posedge clk);
      #1 bus1.req = 1'(v);
      @(negedge clk);
      #1;
      checks++;
      if (bus1.grant !== 1'b1) begin errors++; $display("FAIL n1_grant req=%0d got %b want 1", v, bus1.grant); end
      checks++;
      if (bus1.grant_idx !== 1'b0) begin errors++; $display("FAIL n1_idx req=%0d got %b want 0", v, bus1.grant_idx); end
      checks++;
      if (bus1.req_any !== 1'(v)) begin errors++; $display("FAIL n1_any req=%0d got %b want %0d", v, bus1.req_any, v); end
    end
    @(posedge clk);
    #1 bus1.req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus1.grant !== 1'b1) begin errors++; $display("FAIL n1_park got %b want 1", bus1.grant); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b1;
    bus8.req = 8'h00;
    bus1.req = 1'b0;
    test_reset();
    test_sweep();
    test_park();
    test_priority();
    test_reset_mid();
    test_n1();
    @(posedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abus_lf_arbiter.md
# abus_lf_arbiter

Lower-first (fixed-priority) bus arbiter for the abus interconnect: among N requesting masters it grants the lowest-indexed one, combinationally in the same cycle. When no master requests, the grant parks on the last granted master, so exactly one grant bit is high in every cycle. It sits between the abus master request lines and the bus multiplexer select.

## Interface
- N, default 8, number of masters (N ≥ 1); master 0 has highest priority.
- clk  input  1  bus clock; the park register updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; the design has one clock and asynchronous active-low reset.
- req  input  N  request vector; bit i high means master i requests the bus.
- grant  output  N  one-hot grant vector.
- grant_idx  output  max(1,$clog2(N))  binary index of the set bit of grant.
- req_any  output  1  OR-reduction of req.

## Operation
- If req ≠ 0, grant is the lowest set bit of req: req & (~req + 1), computed at N-bit width.
- If req = 0, grant equals park, the registered last grant.
- park register, N bits, one-hot:
  - Asynchronous reset value is 1 (master 0).
  - On each rising clk edge with req ≠ 0, park loads the current grant.
  - When req = 0, park holds its value.
- grant is always exactly one-hot, including directly after reset and in all-zero request cycles.
- grant_idx is the encoding of grant.
- req_any is 1 exactly when req ≠ 0.
- No fairness or rotation. A steady request from master i starves every master j > i by design.
- N = 1: grant = 1 and grant_idx = 0 always.
- X on req is not specified.
- Reset value of every output while rst_n is low, driven by the combinational path:
  - req = 0: grant = 1, grant_idx = 0, req_any = 0.
  - req ≠ 0: lowest-set-bit grant.

## Timing
- grant, grant_idx and req_any are combinational from req (and park), with zero-cycle latency: a request applied at a clock edge is granted before the next edge.
- park changes only on the rising clk edge, or asynchronously on rst_n falling.
- No handshake; the requester holds req for as long as it needs the bus.
- Simultaneous requests: the lowest index wins in the same cycle.
- Request drop to 0: the grant stays on the previous winner (parked) with no glitch to zero.
- Reset mid-operation: park returns to master 0 immediately.
  - Active requests still resolve combinationally.
  - The first rising edge after rst_n releases loads park normally.
- Reset deassertion is synchronized externally.

## Structure
- Shared package abus_pkg:
  - function lsb_onehot(vec), returning the lowest set bit.
  - function onehot2bin(vec), returning the index.
  - Common abus width localparams.
- One sub-module, abus_prio_lsb: a parameterized N-bit lowest-one priority encoder with outputs onehot, index and any.
  - The top instantiates it and adds the park register and output mux.

## Test plan
- Exhaustive sweep, N = 8: after reset, apply req = 0…255, one value per cycle, and check at the falling edge:
  - grant = lowest set bit, or park when req = 0.
  - Per-master grant counts are 129, 64, 32, 16, 8, 4, 2, 1.
  - Every master is granted at least once; master 0 has the maximum count.
- One-hot check every cycle of every test: $onehot(grant), and grant_idx matches grant.
- Park: req = 0x08 then req = 0x00 for 3 cycles -> grant = 0x08 and grant_idx = 3 throughout; then req = 0x30 -> grant = 0x10.
- Priority collisions: req = 0xFF -> grant 0x01; req = 0xFE -> 0x02; req = 0x80 -> 0x80; req = 0xA0 -> 0x20.
- Reset mid-operation: park on 0x40, assert rst_n low between edges with req = 0 -> grant becomes 0x01 immediately; with req = 0x04 during reset -> grant = 0x04.
- N = 1 build: grant = 1 and grant_idx = 0 for req 0 and 1; req_any follows req.
